// File: rtl/pipe_stage_reg_elastic.sv
// Elastic DEPTH-stage pipeline register with valid/ready handshake, bubble collapse,
// control flush and occupancy count. Optional stall counter under `PIPE_STALL_STATS_EN`.
module pipe_stage_reg_elastic #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 9,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  count
`ifdef PIPE_STALL_STATS_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  logic [DEPTH-1:0]  r_v;
  logic [CTRL_W-1:0] r_ctrl [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [CNT_W-1:0]  r_count;

  logic [DEPTH-1:0]  w_adv;
  logic              w_accept;
  logic              w_consume;

  // Advance chain: a stage moves if it is empty or the stage ahead of it moves.
  always_comb begin
    logic l_adv;
    w_adv = '0;
    l_adv = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      l_adv    = ~r_v[i] | l_adv;
      w_adv[i] = l_adv;
    end
  end

  assign in_ready  = w_adv[0] & ~flush & ~rst;
  assign w_accept  = in_valid & in_ready;
  assign w_consume = r_v[DEPTH-1] & out_ready;

  // Stage registers; ctrl is stored zeroed for bubbles so ctrl_out never leaks enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ctrl[i] <= '0;
        r_data[i] <= '0;
      end
    end else if (flush) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ctrl[i] <= '0;
      end
    end else begin
      if (w_adv[0]) begin
        r_v[0]    <= w_accept;
        r_ctrl[0] <= w_accept ? ctrl_in : {CTRL_W{1'b0}};
        r_data[0] <= data_in;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_adv[i]) begin
          r_v[i]    <= r_v[i-1];
          r_ctrl[i] <= r_ctrl[i-1];
          r_data[i] <= r_data[i-1];
        end
      end
    end
  end

  // Occupancy: accept and consume in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_count <= '0;
    end else begin
      case ({w_accept, w_consume})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid = r_v[DEPTH-1];
  assign ctrl_out  = r_ctrl[DEPTH-1];
  assign data_out  = r_data[DEPTH-1];
  assign count     = r_count;

`ifdef PIPE_STALL_STATS_EN
  logic [15:0] r_stall;

  // Saturating back-pressure counter; survives flush so it reflects the whole run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= 16'd0;
    end else if (r_v[DEPTH-1] && !out_ready && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end else begin
      r_stall <= r_stall;
    end
  end

  assign stall_cycles = r_stall;
`endif

endmodule
